// File: rtl/mdu_pkg.sv
// Shared types, sizes and op-decode helpers for the RV64M multiply/divide sequencer.
// Optional build macro MDU_FAST_MUL_EN (used in mdu_seq) selects single-cycle multiplies.
package mdu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned ACC_W  = 2 * XLEN;
  localparam int unsigned ITER_D = 64;
  localparam int unsigned ITER_W = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } mdu_funct3_e;

  typedef struct packed {
    logic        word;
    mdu_funct3_e f3;
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  // Divide family (quotient/remainder) versus multiply family.
  function automatic logic is_div(input mdu_funct3_e f);
    return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  // rs1 treated as two's complement.
  function automatic logic is_signed_a(input mdu_funct3_e f);
    return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  // rs2 treated as two's complement.
  function automatic logic is_signed_b(input mdu_funct3_e f);
    return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

  // Upper accumulator half: high product word, or the remainder for divides.
  function automatic logic is_high(input mdu_funct3_e f);
    return f inside {F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU};
  endfunction

  // *W results are sign-extended from bit 31.
  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic w);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage <-> multiply/divide sequencer handshake and data bus.
interface mdu_if;
  import mdu_pkg::*;

  logic            clear;
  logic            start;
  mdu_op_t         op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output clear, start, op, src1, src2,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  clear, start, op, src1, src2,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration on the shared accumulator: shift-add or restoring shift-subtract.
module mdu_step
  import mdu_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [XLEN-1:0]  opnd_i,
  input  logic             div_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] rem_sub;
  logic            fits;

  // Multiply: {hi,lo}, lo holds the remaining multiplier. Divide: {rem,quo}, quo shifts dividend out.
  always_comb begin
    addend  = acc_i[0] ? opnd_i : '0;
    sum     = {1'b0, acc_i[ACC_W-1:XLEN]} + {1'b0, addend};
    shifted = {acc_i[ACC_W-1:XLEN], acc_i[XLEN-1]};
    fits    = shifted >= {1'b0, opnd_i};
    rem_sub = shifted[XLEN-1:0] - opnd_i;
    if (div_i) begin
      acc_o = fits ? {rem_sub, acc_i[XLEN-2:0], 1'b1}
                   : {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: FSM, iteration counter, sign fix-up, result register.
// Build option: define MDU_FAST_MUL_EN for single-cycle multiplies (divides still iterate).
module mdu_seq
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q, acc_step;
  logic [XLEN-1:0]  opnd_q, result_q;
  mdu_op_t          op_q;
  logic             neg_q;
  logic             done_q, busy_q;
  logic             done_d, busy_d, stall_c;
  logic             accept_c;

  logic             word_c, div_c, sa_c, sb_c;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag;
  logic             div_zero_c, div_ovf_c, special_c, fast_c, skip_c;
  logic [XLEN-1:0]  special_raw, special_res, fast_res;
  logic [ACC_W-1:0] acc_init;
  logic [XLEN-1:0]  opnd_init;
  logic             neg_init;

  // Final sign correction, half select and *W extension from a finished accumulator.
  function automatic logic [XLEN-1:0] fix_up(input logic [ACC_W-1:0] acc,
                                             input mdu_op_t o, input logic neg);
    logic [ACC_W-1:0] full;
    logic [XLEN-1:0]  half;
    logic             dv;
    dv   = is_div(o.f3);
    full = (!dv && o.word) ? ACC_W'(acc[XLEN+ITER_W-1:ITER_W]) : acc;
    if (!dv && neg) full = -full;
    half = is_high(o.f3) ? full[ACC_W-1:XLEN] : full[XLEN-1:0];
    if (dv && neg) half = -half;
    return wext(half, o.word);
  endfunction

  assign accept_c = (state_q == S_IDLE) && bus.start && !bus.clear;
  assign skip_c   = special_c | fast_c;

  // Operand extension, magnitudes, special-case detection and accumulator preload.
  always_comb begin
    word_c     = bus.op.word;
    div_c      = is_div(bus.op.f3);
    sa_c       = is_signed_a(bus.op.f3);
    sb_c       = is_signed_b(bus.op.f3);
    a_ext      = word_c ? {{(XLEN-32){sa_c & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    b_ext      = word_c ? {{(XLEN-32){sb_c & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
    a_mag      = (sa_c && a_ext[XLEN-1]) ? -a_ext : a_ext;
    b_mag      = (sb_c && b_ext[XLEN-1]) ? -b_ext : b_ext;
    div_zero_c = div_c && (b_ext == '0);
    div_ovf_c  = div_c && sa_c && (b_ext == '1) &&
                 (a_ext == (word_c ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special_c  = div_zero_c | div_ovf_c;
    if (div_zero_c) special_raw = is_high(bus.op.f3) ? a_ext : '1;
    else            special_raw = is_high(bus.op.f3) ? '0 : a_ext;
    special_res = wext(special_raw, word_c);
    if (div_c && is_high(bus.op.f3)) neg_init = sa_c & a_ext[XLEN-1];
    else neg_init = (sa_c & a_ext[XLEN-1]) ^ (sb_c & b_ext[XLEN-1]);
    if (div_c) begin
      acc_init  = {{XLEN{1'b0}}, (word_c ? (a_mag << ITER_W) : a_mag)};
      opnd_init = b_mag;
    end else begin
      acc_init  = {{XLEN{1'b0}}, b_mag};
      opnd_init = a_mag;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [ACC_W-1:0] fa_c, fb_c, fprod_c;

  // Single-cycle product of the 65-bit sign/zero-extended operands.
  always_comb begin
    fa_c     = {{(ACC_W-XLEN){sa_c & a_ext[XLEN-1]}}, a_ext};
    fb_c     = {{(ACC_W-XLEN){sb_c & b_ext[XLEN-1]}}, b_ext};
    fprod_c  = fa_c * fb_c;
    fast_c   = !div_c;
    fast_res = wext(is_high(bus.op.f3) ? fprod_c[ACC_W-1:XLEN] : fprod_c[XLEN-1:0], word_c);
  end
`else
  // Multiplies always iterate in this build.
  always_comb begin
    fast_c   = 1'b0;
    fast_res = '0;
  end
`endif

  mdu_step u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q.f3)),
    .acc_o  (acc_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = skip_c ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.clear) state_d = S_IDLE;
  end

  // Output decode: stall is live from the accepting cycle through the last CALC cycle.
  always_comb begin
    stall_c = accept_c || (state_q == S_CALC);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  // Datapath: operand latch, per-cycle step, counter and result capture on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= mdu_op_t'(4'b0000);
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (bus.clear) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      op_q   <= bus.op;
      acc_q  <= acc_init;
      opnd_q <= opnd_init;
      neg_q  <= neg_init;
      if (skip_c) begin
        cnt_q    <= '0;
        result_q <= special_c ? special_res : fast_res;
      end else begin
        cnt_q <= word_c ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
      end
    end else if (state_q == S_CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) result_q <= fix_up(acc_step, op_q, neg_q);
    end
  end

  assign bus.stall_req = stall_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomized check of mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  mdu_if bus();

  mdu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext_src(input logic [63:0] v, input logic w, input logic sgn);
    if (!w) return v;
    return sgn ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
  endfunction

  // Reference result from the RISC-V M semantics using plain wide arithmetic.
  function automatic logic [63:0] model(input logic [3:0] opv, input logic [63:0] a, input logic [63:0] b);
    logic         w;
    logic [2:0]   f;
    logic [63:0]  x, y, r;
    logic [127:0] p;
    logic         ovf;
    w   = opv[3];
    f   = opv[2:0];
    x   = ext_src(a, w, f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    y   = ext_src(b, w, f inside {3'd0, 3'd1, 3'd4, 3'd6});
    ovf = (y == 64'hFFFF_FFFF_FFFF_FFFF) && (x == 64'h8000_0000_0000_0000);
    p   = '0;
    r   = '0;
    case (f)
      3'd0: r = x * y;
      3'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; r = p[127:64]; end
      3'd2: begin p = {{64{x[63]}}, x} * {64'h0, y};       r = p[127:64]; end
      3'd3: begin p = {64'h0, x} * {64'h0, y};             r = p[127:64]; end
      3'd4: r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? x : 64'($signed(x) / $signed(y));
      3'd5: r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : ovf ? 64'h0 : 64'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Expected cycles from start to done.
  function automatic int model_lat(input logic [3:0] opv, input logic [63:0] a, input logic [63:0] b);
    logic        w;
    logic [2:0]  f;
    logic [63:0] x, y, mn;
    w  = opv[3];
    f  = opv[2:0];
    x  = ext_src(a, w, f inside {3'd4, 3'd6});
    y  = ext_src(b, w, f inside {3'd4, 3'd6});
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (f[2]) begin
      if (y == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && y == 64'hFFFF_FFFF_FFFF_FFFF && x == mn) return 1;
      return w ? 33 : 65;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return w ? 33 : 65;
`endif
  endfunction

  // Issue one op at the next cycle and follow it to its done pulse; returns in the done cycle.
  task automatic run_op(input string tag, input logic [3:0] opv, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp_r;
    int          exp_l, cyc;
    logic        got, stall_ok;
    exp_r = model(opv, a, b);
    exp_l = model_lat(opv, a, b);
    @(negedge clk);
    chk({tag, ".idle_done"}, 64'(bus.done), 64'd0);
    bus.start = 1'b1;
    bus.op    = mdu_op_t'(opv);
    bus.src1  = a;
    bus.src2  = b;
    #1 chk({tag, ".stall_start"}, 64'(bus.stall_req), 64'd1);
    cyc      = 0;
    got      = 1'b0;
    stall_ok = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      #1;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_l));
    chk({tag, ".result"}, bus.result, exp_r);
    chk({tag, ".stall_done"}, 64'(bus.stall_req), 64'd0);
    chk({tag, ".busy_done"}, 64'(bus.busy), 64'd1);
    chk({tag, ".stall_calc"}, 64'(stall_ok), 64'd1);
  endtask

  initial begin
    logic        saw;
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b;
    int          sel;

    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.op    = mdu_op_t'(4'b0000);
    bus.src1  = '0;
    bus.src2  = '0;

    #2;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.stall", 64'(bus.stall_req), 64'd0);
    chk("rst.result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 4'b0000, 64'd7, -64'sd3);
    chk("mul.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    #1 chk("mul.busy_after", 64'(bus.busy), 64'd0);
    chk("mul.done_after", 64'(bus.done), 64'd0);

    run_op("divw_ovf", 4'b1100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divw_ovf.lit", bus.result, 64'hFFFF_FFFF_8000_0000);
    run_op("remu_zero", 4'b0111, 64'd100, 64'd0);
    chk("remu_zero.lit", bus.result, 64'd100);
    run_op("div_zero", 4'b0100, 64'd12345, 64'd0);
    chk("div_zero.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulhu", 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mulhu.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op("b2b_rem", 4'b0110, -64'sd7, 64'd2);
    chk("b2b_rem.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("b2b_divuw", 4'b1101, 64'h0000_0000_FFFF_FFFF, 64'd2);
    chk("b2b_divuw.lit", bus.result, 64'h0000_0000_7FFF_FFFF);

    // Flush mid-divide: no done pulse may follow.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = mdu_op_t'(4'b0100);
    bus.src1  = -64'sd20;
    bus.src2  = 64'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 chk("clr.busy_before", 64'(bus.busy), 64'd1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    #1 chk("clr.busy", 64'(bus.busy), 64'd0);
    chk("clr.stall", 64'(bus.stall_req), 64'd0);
    saw = 1'b0;
    repeat (70) begin
      @(negedge clk);
      #1 if (bus.done === 1'b1) saw = 1'b1;
    end
    chk("clr.no_done", 64'(saw), 64'd0);

    // start together with clear is not accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.clear = 1'b1;
    bus.op    = mdu_op_t'(4'b0000);
    bus.src1  = 64'd5;
    bus.src2  = 64'd6;
    #1 chk("sc.stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    #1 chk("sc.busy", 64'(bus.busy), 64'd0);
    saw = 1'b0;
    repeat (70) begin
      @(negedge clk);
      #1 if (bus.done === 1'b1) saw = 1'b1;
    end
    chk("sc.no_done", 64'(saw), 64'd0);

    // Asynchronous reset in the middle of an op.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = mdu_op_t'(4'b0100);
    bus.src1  = 64'd100;
    bus.src2  = 64'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("mrst.busy_before", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("mrst.busy", 64'(bus.busy), 64'd0);
    chk("mrst.done", 64'(bus.done), 64'd0);
    chk("mrst.stall", 64'(bus.stall_req), 64'd0);
    chk("mrst.result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ops, biased toward the divide special cases and small operands.
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      w   = ($urandom_range(0, 2) == 0) && (f == 3'd0 || f[2]);
      sel = $urandom_range(0, 9);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case (sel)
        0: b = w ? {$urandom, 32'h0} : 64'h0;
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), {w, f}, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
